tile_renderer: RTL and testbench
================================

// Module: tile_renderer
// PURPOSE
//  Pixel colour stage that sits directly after the VGA timing generator.
//  Takes display_on, x_pos/y_pos and the two syncs, looks each pixel up in a
//  20x15 grid of 32x32-pixel Bomberman tiles, and emits 12-bit RGB plus delayed
//  syncs. The tile map is written by the game logic through a one-port write
//  interface. A player sprite is overlaid on one tile.
// PARAMETERS
//  TILES_X    20   tiles per row (640/32)
//  TILES_Y    15   tile rows (480/32)
//  PIPE_LAT   3    pixel-path latency in cycles; fixed, not tunable
// PORTS
//  pix_clk      in   1   pixel clock (all logic on this single clock)
//  reset        in   1   asynchronous, active-high reset
//  display_on   in   1   visible-pixel flag from the timing generator
//  hsync_in     in   1   Hsync from the timing generator (active low)
//  vsync_in     in   1   Vsync from the timing generator (active low)
//  x_pos        in   10  visible column, 0..639 when display_on
//  y_pos        in   10  visible row, 0..479 when display_on
//  map_we       in   1   tile-map write strobe
//  map_waddr    in   9   tile index ty*20+tx, 0..299
//  map_wdata    in   3   tile code
//  player_tx    in   5   player tile column, 0..19
//  player_ty    in   4   player tile row, 0..14
//  rgb          out  12  {R[3:0],G[3:0],B[3:0]}
//  hsync_out    out  1   hsync_in delayed PIPE_LAT cycles
//  vsync_out    out  1   vsync_in delayed PIPE_LAT cycles
//  frame_tick   out  1   one-cycle pulse on each vsync_in falling edge
// BEHAVIOUR
//  Reset:
//  - rgb=0, hsync_out=1, vsync_out=1, frame_tick=0.
//  - All pipeline valid bits and the player shadow registers go to 0.
//  - Map RAM contents are NOT cleared by reset.
//  Pipeline (3 cycles; display_on, syncs and pixel offsets ride alongside):
//  - S1: register tx=x_pos[9:5], ty=y_pos[9:5], px=x_pos[4:0], py=y_pos[4:0].
//    Compute idx=(ty<<4)+(ty<<2)+tx as 9 bits.
//    If x_pos>=640 or y_pos>=480, force idx=0; blanking wrap values are harmless.
//  - S2: synchronous read map[idx], 300x3 RAM.
//  - S3: colour decode into the rgb register.
//    If the delayed display_on is 0, rgb=0.
//  Tile codes (px,py are the 5-bit offsets within the tile):
//  - 0 floor: 0x2A2.
//  - 1 wall: 0x444 where px or py is 0 or 31, else 0x888.
//  - 2 brick: 0xCCC where py[2:0]==0 or px[3:0]==(py[3]?8:0), else 0xA52.
//  - 3 bomb: 0x000 where (px-16)^2+(py-16)^2<100, else floor.
//    The differences are 6-bit signed and the sum is 11-bit unsigned.
//  - 4 flame: 0xF80.
//  - 5 powerup: 0xFFF where px,py both in 12..19, else 0x00F.
//  - 6,7 reserved: 0xF0F (debug magenta).
//  Player overlay:
//  - Condition: the S1 tile equals the shadow (tx,ty) and px,py are both in 8..23.
//  - rgb=0xFF0, overriding any tile colour.
//  - The shadow registers load player_tx/ty only on the frame_tick cycle, so there is no mid-frame tearing.
//  Map writes:
//  - Take effect on the pix_clk edge where map_we=1.
//  - map_waddr>=300 is ignored, with no aliasing.
//  - A write and a read of the same index in the same cycle: the read returns the OLD code.
//  frame_tick:
//  - Registered edge detect of vsync_in (1 then 0).
//  - Asserts one cycle after the edge is seen at the input.
//  Reset mid-line: outputs go to their reset values immediately. The first valid rgb appears 3 cycles after reset is released.
// TESTING
//  1. Reset held, any inputs -> rgb=0, hsync_out=vsync_out=1, frame_tick=0.
//     Release reset -> syncs follow the inputs 3 cycles later.
//  2. Write map[0]=1. Drive x=0,y=0,display_on=1 -> rgb=0x444 exactly 3 cycles later.
//     x=5,y=5 -> 0x888.
//  3. Write map[21]=3 (tx=1,ty=1). x=48,y=48 -> 0x000. x=33,y=33 -> 0x2A2.
//  4. Write same cycle as read of idx 0: old 0, new 4 -> old colour first (0x2A2); next visit -> 0xF80.
//     map_waddr=300 write -> map[0..299] unchanged.
//  5. player_tx=2, player_ty=0 changed mid-frame -> no overlay until after a vsync fall.
//     Then x=72,y=16 -> 0xFF0; x=66,y=16 -> tile colour.
//  6. display_on=0 with x_pos=700 (wrapped) -> rgb=0.
//     vsync_in 1->0 -> a single-cycle frame_tick pulse.

Source files
------------

// File: rtl/tile_renderer.sv
// Pixel colour stage: looks each visible pixel up in a 20x15 map of 32x32 tiles,
// overlays the player sprite and delays the syncs to match the 3-cycle pixel path.
module tile_renderer #(
  parameter int unsigned TILES_X  = 20,
  parameter int unsigned TILES_Y  = 15,
  parameter int unsigned PIPE_LAT = 3
) (
  input  logic        pix_clk,
  input  logic        reset,
  input  logic        display_on,
  input  logic        hsync_in,
  input  logic        vsync_in,
  input  logic [9:0]  x_pos,
  input  logic [9:0]  y_pos,
  input  logic        map_we,
  input  logic [8:0]  map_waddr,
  input  logic [2:0]  map_wdata,
  input  logic [4:0]  player_tx,
  input  logic [3:0]  player_ty,
  output logic [11:0] rgb,
  output logic        hsync_out,
  output logic        vsync_out,
  output logic        frame_tick
);

  localparam int unsigned MapDepth = TILES_X * TILES_Y;
  localparam logic [9:0]  XLimit   = 10'(TILES_X * 32);
  localparam logic [9:0]  YLimit   = 10'(TILES_Y * 32);

  logic [2:0] r_map [MapDepth];

  // S1 / S2 pipeline registers
  logic [4:0] r1_px, r1_py, r2_px, r2_py;
  logic [8:0] r1_idx;
  logic       r1_de, r1_ov, r2_de, r2_ov;
  logic [2:0] r2_code;

  logic [PIPE_LAT-1:0] r_hs_dly, r_vs_dly;
  logic                r_vs_prev;
  logic [4:0]          r_sh_tx;
  logic [3:0]          r_sh_ty;

  logic [4:0]  w_tx, w_ty;
  logic [8:0]  w_idx;
  logic        w_in_range, w_ov;
  logic [11:0] w_colour;

  assign w_tx       = x_pos[9:5];
  assign w_ty       = y_pos[9:5];
  assign w_in_range = (x_pos < XLimit) && (y_pos < YLimit);
  // ty*20 + tx without a multiplier
  assign w_idx      = w_in_range ?
                      (({4'b0, w_ty} << 4) + ({4'b0, w_ty} << 2) + {4'b0, w_tx}) : 9'd0;
  assign w_ov       = (w_tx == r_sh_tx) && (w_ty == {1'b0, r_sh_ty}) &&
                      (x_pos[4:0] >= 5'd8) && (x_pos[4:0] <= 5'd23) &&
                      (y_pos[4:0] >= 5'd8) && (y_pos[4:0] <= 5'd23);

  // Map RAM is not reset; the read returns the pre-write code on a collision
  always_ff @(posedge pix_clk) begin
    if (map_we && (map_waddr < 9'(MapDepth))) begin
      r_map[map_waddr] <= map_wdata;
    end
    r2_code <= r_map[r1_idx];
  end

  logic signed [5:0]  w_dx, w_dy;
  logic signed [11:0] w_dx_sq, w_dy_sq;
  logic [10:0]        w_dist;
  logic               w_wall_edge, w_brick_line, w_pow_core;

  assign w_dx         = $signed({1'b0, r2_px}) - 6'sd16;
  assign w_dy         = $signed({1'b0, r2_py}) - 6'sd16;
  assign w_dx_sq      = 12'(w_dx) * 12'(w_dx);
  assign w_dy_sq      = 12'(w_dy) * 12'(w_dy);
  assign w_dist       = 11'(w_dx_sq) + 11'(w_dy_sq);
  assign w_wall_edge  = (r2_px == 5'd0) || (r2_px == 5'd31) || (r2_py == 5'd0) || (r2_py == 5'd31);
  assign w_brick_line = (r2_py[2:0] == 3'd0) || (r2_px[3:0] == (r2_py[3] ? 4'd8 : 4'd0));
  assign w_pow_core   = (r2_px >= 5'd12) && (r2_px <= 5'd19) &&
                        (r2_py >= 5'd12) && (r2_py <= 5'd19);

  always_comb begin
    w_colour = 12'h000;
    if (r2_de) begin
      if (r2_ov) begin
        w_colour = 12'hFF0;
      end else begin
        case (r2_code)
          3'd0:    w_colour = 12'h2A2;
          3'd1:    w_colour = w_wall_edge ? 12'h444 : 12'h888;
          3'd2:    w_colour = w_brick_line ? 12'hCCC : 12'hA52;
          3'd3:    w_colour = (w_dist < 11'd100) ? 12'h000 : 12'h2A2;
          3'd4:    w_colour = 12'hF80;
          3'd5:    w_colour = w_pow_core ? 12'hFFF : 12'h00F;
          default: w_colour = 12'hF0F;
        endcase
      end
    end
  end

  always_ff @(posedge pix_clk or posedge reset) begin
    if (reset) begin
      r1_px      <= '0;
      r1_py      <= '0;
      r1_idx     <= '0;
      r1_de      <= 1'b0;
      r1_ov      <= 1'b0;
      r2_px      <= '0;
      r2_py      <= '0;
      r2_de      <= 1'b0;
      r2_ov      <= 1'b0;
      rgb        <= '0;
      r_hs_dly   <= '1;
      r_vs_dly   <= '1;
      r_vs_prev  <= 1'b1;
      frame_tick <= 1'b0;
      r_sh_tx    <= '0;
      r_sh_ty    <= '0;
    end else begin
      r1_px      <= x_pos[4:0];
      r1_py      <= y_pos[4:0];
      r1_idx     <= w_idx;
      r1_de      <= display_on;
      r1_ov      <= w_ov;
      r2_px      <= r1_px;
      r2_py      <= r1_py;
      r2_de      <= r1_de;
      r2_ov      <= r1_ov;
      rgb        <= w_colour;
      r_hs_dly   <= {r_hs_dly[PIPE_LAT-2:0], hsync_in};
      r_vs_dly   <= {r_vs_dly[PIPE_LAT-2:0], vsync_in};
      r_vs_prev  <= vsync_in;
      frame_tick <= r_vs_prev & ~vsync_in;
      // Player position only moves at frame boundaries
      if (frame_tick) begin
        r_sh_tx <= player_tx;
        r_sh_ty <= player_ty;
      end
    end
  end

  assign hsync_out = r_hs_dly[PIPE_LAT-1];
  assign vsync_out = r_vs_dly[PIPE_LAT-1];

endmodule

// File: tb/tb_tile_renderer.sv
// Bench for tile_renderer: rule-based colour model checked every cycle plus
// directed pixels with literal expected colours.
module tb_tile_renderer;

  logic        pix_clk = 1'b0;
  logic        reset = 1'b0;
  logic        display_on = 1'b0;
  logic        hsync_in = 1'b1;
  logic        vsync_in = 1'b1;
  logic [9:0]  x_pos = '0;
  logic [9:0]  y_pos = '0;
  logic        map_we = 1'b0;
  logic [8:0]  map_waddr = '0;
  logic [2:0]  map_wdata = '0;
  logic [4:0]  player_tx = '0;
  logic [3:0]  player_ty = '0;
  logic [11:0] rgb;
  logic        hsync_out, vsync_out, frame_tick;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  tile_renderer dut (
    .pix_clk    (pix_clk),
    .reset      (reset),
    .display_on (display_on),
    .hsync_in   (hsync_in),
    .vsync_in   (vsync_in),
    .x_pos      (x_pos),
    .y_pos      (y_pos),
    .map_we     (map_we),
    .map_waddr  (map_waddr),
    .map_wdata  (map_wdata),
    .player_tx  (player_tx),
    .player_ty  (player_ty),
    .rgb        (rgb),
    .hsync_out  (hsync_out),
    .vsync_out  (vsync_out),
    .frame_tick (frame_tick)
  );

  always #5 pix_clk = ~pix_clk;

  task automatic chk(input string name, input logic [11:0] act, input logic [11:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  function automatic int tile_index(input logic [9:0] x, input logic [9:0] y);
    int xi, yi;
    xi = int'(x);
    yi = int'(y);
    if (xi >= 640 || yi >= 480) return 0;
    return (yi / 32) * 20 + xi / 32;
  endfunction

  function automatic logic over(input logic [9:0] x, input logic [9:0] y,
                                input logic [4:0] stx, input logic [3:0] sty);
    int xi, yi, px, py;
    xi = int'(x);
    yi = int'(y);
    px = xi % 32;
    py = yi % 32;
    return (xi / 32 == int'(stx)) && (yi / 32 == int'(sty)) &&
           px >= 8 && px <= 23 && py >= 8 && py <= 23;
  endfunction

  function automatic logic [11:0] colour(input logic [9:0] x, input logic [9:0] y,
                                         input logic de, input logic ov, input logic [2:0] code);
    int px, py, dx, dy;
    px = int'(x) % 32;
    py = int'(y) % 32;
    if (!de) return 12'h000;
    if (ov) return 12'hFF0;
    case (code)
      3'd0: return 12'h2A2;
      3'd1: return (px == 0 || px == 31 || py == 0 || py == 31) ? 12'h444 : 12'h888;
      3'd2: return ((py % 8) == 0 || (px % 16) == (((py / 8) % 2 == 1) ? 8 : 0)) ?
                   12'hCCC : 12'hA52;
      3'd3: begin
        dx = px - 16;
        dy = py - 16;
        return (dx * dx + dy * dy < 100) ? 12'h000 : 12'h2A2;
      end
      3'd4: return 12'hF80;
      3'd5: return (px >= 12 && px <= 19 && py >= 12 && py <= 19) ? 12'hFFF : 12'h00F;
      default: return 12'hF0F;
    endcase
  endfunction

  logic [2:0]  m_map [300];
  logic [9:0]  m_x1, m_y1;
  logic        m_de1, m_ov1;
  logic [11:0] m_pend, m_rgb;
  logic [2:0]  m_hs, m_vs;
  logic        m_vprev, m_tick;
  logic [4:0]  m_stx;
  logic [3:0]  m_sty;

  always @(posedge pix_clk) begin
    if (map_we && int'(map_waddr) < 300) m_map[map_waddr] <= map_wdata;
  end

  // Pixel sampled at edge k looks the map up as it stands at edge k+1, shows after k+2
  always @(posedge pix_clk or posedge reset) begin
    if (reset) begin
      m_x1 <= '0; m_y1 <= '0; m_de1 <= 1'b0; m_ov1 <= 1'b0;
      m_pend <= '0; m_rgb <= '0;
      m_hs <= 3'b111; m_vs <= 3'b111;
      m_vprev <= 1'b1; m_tick <= 1'b0;
      m_stx <= '0; m_sty <= '0;
    end else begin
      m_x1   <= x_pos;
      m_y1   <= y_pos;
      m_de1  <= display_on;
      m_ov1  <= over(x_pos, y_pos, m_stx, m_sty);
      m_pend <= colour(m_x1, m_y1, m_de1, m_ov1, m_map[tile_index(m_x1, m_y1)]);
      m_rgb  <= m_pend;
      m_hs   <= {m_hs[1:0], hsync_in};
      m_vs   <= {m_vs[1:0], vsync_in};
      m_tick <= m_vprev & ~vsync_in;
      m_vprev <= vsync_in;
      if (m_tick) begin
        m_stx <= player_tx;
        m_sty <= player_ty;
      end
    end
  end

  always @(negedge pix_clk) begin
    if (chk_en) begin
      chk("model_rgb", rgb, m_rgb);
      chk("model_hsync", {11'd0, hsync_out}, {11'd0, m_hs[2]});
      chk("model_vsync", {11'd0, vsync_out}, {11'd0, m_vs[2]});
      chk("model_tick", {11'd0, frame_tick}, {11'd0, m_tick});
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic wr(input int addr, input logic [2:0] data);
    @(negedge pix_clk);
    map_we    = 1'b1;
    map_waddr = 9'(addr);
    map_wdata = data;
    @(negedge pix_clk);
    map_we    = 1'b0;
  endtask

  task automatic expect_pix(input string name, input int x, input int y, input logic de,
                            input logic [11:0] exp);
    @(negedge pix_clk);
    x_pos      = 10'(x);
    y_pos      = 10'(y);
    display_on = de;
    repeat (3) @(posedge pix_clk);
    @(negedge pix_clk);
    chk(name, rgb, exp);
  endtask

  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1 reset = 1'b1;
    chk_en = 1'b1;
    // Reset held with arbitrary inputs
    repeat (4) begin
      @(negedge pix_clk);
      hsync_in   = 1'($urandom);
      vsync_in   = 1'($urandom);
      display_on = 1'($urandom);
      x_pos      = 10'($urandom_range(0, 639));
      #1;
      chk("rst_rgb", rgb, 12'h000);
      chk("rst_hsync", {11'd0, hsync_out}, 12'd1);
      chk("rst_vsync", {11'd0, vsync_out}, 12'd1);
      chk("rst_tick", {11'd0, frame_tick}, 12'd0);
    end
    @(negedge pix_clk);
    hsync_in = 1'b1; vsync_in = 1'b1; display_on = 1'b0;
    @(negedge pix_clk);
    reset    = 1'b0;
    hsync_in = 1'b0;
    repeat (2) @(posedge pix_clk);
    @(negedge pix_clk);
    chk("hsync_not_yet", {11'd0, hsync_out}, 12'd1);
    @(posedge pix_clk);
    @(negedge pix_clk);
    chk("hsync_lat3", {11'd0, hsync_out}, 12'd0);
    hsync_in = 1'b1;

    for (int i = 0; i < 300; i++) wr(i, 3'd0);

    wr(0, 3'd1);
    expect_pix("wall_edge", 0, 0, 1'b1, 12'h444);
    expect_pix("wall_inner", 5, 5, 1'b1, 12'h888);
    wr(21, 3'd3);
    expect_pix("bomb_centre", 48, 48, 1'b1, 12'h000);
    expect_pix("bomb_outside", 33, 33, 1'b1, 12'h2A2);
    wr(1, 3'd2);
    expect_pix("brick_mortar_row", 32, 0, 1'b1, 12'hCCC);
    expect_pix("brick_face", 33, 1, 1'b1, 12'hA52);
    expect_pix("brick_odd_joint", 40, 9, 1'b1, 12'hCCC);
    wr(3, 3'd5);
    expect_pix("powerup_core", 108, 12, 1'b1, 12'hFFF);
    expect_pix("powerup_rim", 96, 0, 1'b1, 12'h00F);
    wr(4, 3'd6);
    expect_pix("reserved", 128, 0, 1'b1, 12'hF0F);

    // Write and read of index 0 in the same cycle
    wr(0, 3'd0);
    @(negedge pix_clk);
    x_pos = 10'd0; y_pos = 10'd0; display_on = 1'b1;
    @(posedge pix_clk);
    @(negedge pix_clk);
    map_we = 1'b1; map_waddr = 9'd0; map_wdata = 3'd4;
    @(posedge pix_clk);
    @(negedge pix_clk);
    map_we = 1'b0;
    @(posedge pix_clk);
    @(negedge pix_clk);
    chk("collide_old", rgb, 12'h2A2);
    @(posedge pix_clk);
    @(negedge pix_clk);
    chk("collide_new", rgb, 12'hF80);
    wr(300, 3'd7);
    expect_pix("oob_write_idx0", 0, 0, 1'b1, 12'hF80);
    expect_pix("oob_write_idx44", 128, 64, 1'b1, 12'h2A2);

    // Player move is deferred to the next frame
    wr(2, 3'd0);
    @(negedge pix_clk);
    player_tx = 5'd2; player_ty = 4'd0;
    expect_pix("no_tearing", 72, 16, 1'b1, 12'h2A2);
    @(negedge pix_clk);
    vsync_in = 1'b0;
    @(posedge pix_clk);
    @(negedge pix_clk);
    chk("tick_high", {11'd0, frame_tick}, 12'd1);
    @(negedge pix_clk);
    chk("tick_single", {11'd0, frame_tick}, 12'd0);
    vsync_in = 1'b1;
    expect_pix("player_overlay", 72, 16, 1'b1, 12'hFF0);
    expect_pix("player_edge_off", 66, 16, 1'b1, 12'h2A2);
    expect_pix("blank_wrapped", 700, 16, 1'b0, 12'h000);

    // Reset in the middle of a visible line
    expect_pix("pre_reset", 72, 16, 1'b1, 12'hFF0);
    #2 reset = 1'b1;
    #1;
    chk("midline_rst_rgb", rgb, 12'h000);
    @(negedge pix_clk);
    reset = 1'b0;
    repeat (3) @(posedge pix_clk);
    @(negedge pix_clk);
    chk("post_reset_pix", rgb, 12'h2A2);

    repeat (5) @(negedge pix_clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
